// File: rtl/rs232_xmit.sv
// 8N1 UART transmitter with RTS flow control and a fractional baud accumulator.
// Define RS232_XMIT_PARITY_EN to insert an even-parity bit before the stop bit.
module rs232_xmit #(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 12000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       rxd_pin,
  input  logic       rtsn_pin,
  output logic       busy
);

  localparam int ACC_W = $clog2(CLOCK_FREQ + BAUD_RATE);
  localparam logic [ACC_W-1:0] BAUD_INC = ACC_W'(BAUD_RATE);
  localparam logic [ACC_W-1:0] CLK_MOD  = ACC_W'(CLOCK_FREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RS232_XMIT_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n, acc_sum;
  logic [7:0]       shreg, shreg_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic             rxd_n;
  logic             rts_meta, rts_sync;
  logic             cts, tick, accept;
`ifdef RS232_XMIT_PARITY_EN
  logic             parity, parity_n;
`endif

  assign cts     = ~rts_sync;
  assign busy    = (state != S_IDLE);
  assign ready   = (state == S_IDLE) && cts && !reset;
  assign accept  = valid && ready;
  // Sum cannot wrap: ACC_W bits hold CLOCK_FREQ + BAUD_RATE - 1.
  assign acc_sum = acc + BAUD_INC;
  assign tick    = busy && (acc_sum >= CLK_MOD);

  // NOTE: every output of this block gets a default first, so paths that
  // don't assign it hold the current value instead of inferring a latch.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    rxd_n     = rxd_pin;
`ifdef RS232_XMIT_PARITY_EN
    parity_n  = parity;
`endif
    if (busy) acc_n = tick ? acc_sum - CLK_MOD : acc_sum;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n   = S_START;
          shreg_n   = data;
          bit_cnt_n = '0;
          acc_n     = '0;
          rxd_n     = 1'b0;
`ifdef RS232_XMIT_PARITY_EN
          parity_n  = ^data;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          state_n = S_DATA;
          rxd_n   = shreg[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_n   = shreg >> 1;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef RS232_XMIT_PARITY_EN
            state_n = S_PARITY;
            rxd_n   = parity;
`else
            state_n = S_STOP;
            rxd_n   = 1'b1;
`endif
          end else begin
            rxd_n = shreg[1];
          end
        end
      end
`ifdef RS232_XMIT_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_n = S_STOP;
          rxd_n   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          state_n = S_IDLE;
          rxd_n   = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        rxd_n   = 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      acc      <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      rxd_pin  <= 1'b1;
      rts_meta <= 1'b1;
      rts_sync <= 1'b1;
`ifdef RS232_XMIT_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      rxd_pin  <= rxd_n;
      rts_meta <= rtsn_pin;
      rts_sync <= rts_meta;
`ifdef RS232_XMIT_PARITY_EN
      parity   <= parity_n;
`endif
    end
  end

endmodule

// File: tb/tb_rs232_xmit.sv
// Directed bench for rs232_xmit: per-bit window timing, flow control, back-to-back, reset.
module tb_rs232_xmit;

`ifdef RS232_XMIT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NB     = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NB     = 10;
`endif
  localparam int LEN = PAR_EN ? 122 : 111;

  // ceil(j*133/12): last cycle of frame bit j-1, counted from the first start-bit cycle
  int bnd [0:11] = '{0, 12, 23, 34, 45, 56, 67, 78, 89, 100, 111, 122};

  logic       clock, reset, valid, ready, rxd_pin, rtsn_pin, busy;
  logic [7:0] data;

  int errors = 0;
  int checks = 0;

  rs232_xmit #(.CLOCK_FREQ(133000000), .BAUD_RATE(12000000)) dut (
    .clock   (clock),
    .reset   (reset),
    .data    (data),
    .valid   (valid),
    .ready   (ready),
    .rxd_pin (rxd_pin),
    .rtsn_pin(rtsn_pin),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] d;
    logic       par;
    bit         hold;
    string      name;
  } vec_t;

  vec_t vecs [0:4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_bit(input int j, input logic [7:0] d, input logic par);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (j == 9 && PAR_EN) return par;
    return 1'b1;
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic start_frame(input logic [7:0] d, input int limit, input string nm,
                             output int lat);
    valid = 1'b1;
    data  = d;
    lat   = 0;
    while (ready !== 1'b1 && lat < limit) begin
      @(negedge clock);
      lat++;
    end
    check({nm, " accept"}, ready, 1'b1);
    @(posedge clock);
  endtask

  // Checks every cycle of one frame, then the idle cycle that follows it.
  task automatic frame(input logic [7:0] d, input logic par, input string nm,
                       input bit hold, input logic [7:0] nd, input int rts_idx,
                       input logic exp_ready);
    int match [0:10];
    int busy_cnt = 0;
    for (int j = 0; j < 11; j++) match[j] = 0;
    for (int idx = 1; idx <= LEN; idx++) begin
      int j = 0;
      @(negedge clock);
      if (idx == 1) begin
        if (hold) data = nd;
        else valid = 1'b0;
      end
      if (idx == rts_idx) rtsn_pin = 1'b1;
      while (idx > bnd[j+1]) j++;
      if (rxd_pin === exp_bit(j, d, par)) match[j]++;
      if (busy === 1'b1) busy_cnt++;
    end
    for (int j = 0; j < NB; j++)
      check($sformatf("%s bit%0d cycles", nm, j), match[j], bnd[j+1] - bnd[j]);
    check({nm, " busy cycles"}, busy_cnt, LEN);
    @(negedge clock);
    check({nm, " idle busy"}, busy, 1'b0);
    check({nm, " idle rxd"}, rxd_pin, 1'b1);
    if (hold) check({nm, " idle ready"}, ready, exp_ready);
  endtask

  initial begin
    int lat;
    int cnt;

    vecs[0] = '{d: 8'hA5, par: 1'b0, hold: 1'b0, name: "single_A5"};
    vecs[1] = '{d: 8'h00, par: 1'b0, hold: 1'b1, name: "b2b_00"};
    vecs[2] = '{d: 8'hFF, par: 1'b0, hold: 1'b1, name: "b2b_FF"};
    vecs[3] = '{d: 8'h55, par: 1'b0, hold: 1'b0, name: "b2b_55"};
    vecs[4] = '{d: 8'h07, par: 1'b1, hold: 1'b0, name: "single_07"};

    reset    = 1'b1;
    valid    = 1'b0;
    data     = 8'h00;
    rtsn_pin = 1'b1;
    repeat (3) @(negedge clock);
    check("reset rxd", rxd_pin, 1'b1);
    check("reset ready", ready, 1'b0);
    check("reset busy", busy, 1'b0);
    reset = 1'b0;

    // Host not ready: nothing may start while valid is held
    valid = 1'b1;
    data  = 8'hC3;
    cnt   = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (ready === 1'b0 && rxd_pin === 1'b1 && busy === 1'b0) cnt++;
    end
    check("rts high stall cycles", cnt, 500);
    rtsn_pin = 1'b0;
    start_frame(8'hC3, 6, "flow", lat);
    check("rts fall latency 2..3", (lat >= 2 && lat <= 3), 1'b1);
    frame(8'hC3, 1'b0, "flow_C3", 1'b0, 8'h00, 0, 1'b0);

    // RTS raised mid-frame: frame completes, next byte waits
    start_frame(8'h3C, 6, "rts_mid", lat);
    frame(8'h3C, 1'b0, "rts_mid_3C", 1'b1, 8'h99, 50, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (ready === 1'b0 && busy === 1'b0 && rxd_pin === 1'b1) cnt++;
    end
    check("rts high holds queued byte", cnt, 20);
    rtsn_pin = 1'b0;
    start_frame(8'h99, 6, "queued", lat);
    frame(8'h99, 1'b0, "queued_99", 1'b0, 8'h00, 0, 1'b0);

    // Reset at cycle 40 of a frame; valid held during reset is ignored
    start_frame(8'h0F, 6, "rst_mid", lat);
    for (int idx = 1; idx <= 40; idx++) begin
      @(negedge clock);
      if (idx == 1) valid = 1'b0;
    end
    reset = 1'b1;
    valid = 1'b1;
    data  = 8'h81;
    @(negedge clock);
    check("rst_mid rxd", rxd_pin, 1'b1);
    check("rst_mid ready", ready, 1'b0);
    check("rst_mid busy", busy, 1'b0);
    repeat (2) @(negedge clock);
    check("rst held valid ignored", busy, 1'b0);
    reset = 1'b0;
    start_frame(8'h81, 6, "post_rst", lat);
    frame(8'h81, 1'b0, "post_rst_81", 1'b0, 8'h00, 0, 1'b0);

    // Table: single byte, then three frames streamed with valid held
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || !vecs[i-1].hold) start_frame(vecs[i].d, 6, vecs[i].name, lat);
      else @(posedge clock);
      frame(vecs[i].d, vecs[i].par, vecs[i].name, vecs[i].hold,
            (i < 4) ? vecs[i+1].d : 8'h00, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs232_xmit.md
# rs232_xmit

UART transmitter with hardware flow control for the host link. It takes bytes from an on-chip valid/ready stream (typically a FIFO output) and serialises them onto the host's RXD line as 8N1 frames. Each frame starts only while the host asserts RTS. Bit timing comes from a fractional accumulator, so non-integer clock/baud ratios (e.g. 133 MHz / 12 Mbaud) average exactly to the requested rate.

## Interface
- CLOCK_FREQ, 133000000, system clock frequency in Hz.
- BAUD_RATE, 12000000, line bit rate in Hz. Must satisfy BAUD_RATE ≤ CLOCK_FREQ/2.
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data  input  8  byte to send; LSB is transmitted first.
- valid  input  1  data is valid.
- ready  output  1  block can accept a byte this cycle.
- rxd_pin  output  1  serial line to host; idles high. Registered.
- rtsn_pin  input  1  host RTS, active low, asynchronous. Low means the host can receive.
- busy  output  1  a frame is in progress (state ≠ IDLE).

## Operation
- rtsn_pin passes through a 2-flop synchroniser. Both flops reset to 1 (host not ready). cts = ~sync output.
- States and transitions:
  - IDLE: ready = cts. On valid && ready, latch data into the shift register, clear the accumulator, clear the bit counter, and go to START.
  - START: on tick, go to DATA.
  - DATA: on each tick, shift right and increment the bit counter. On the tick for bit 7, go to PARITY (when compiled in) or STOP.
  - PARITY (optional): on tick, go to STOP.
  - STOP: on tick, go to IDLE.
- rxd_pin is registered. It equals the line value of the state/bit being entered, so the start bit appears on the cycle after acceptance.
- Baud generator:
  - Accumulator width is $clog2(CLOCK_FREQ+BAUD_RATE).
  - In every non-IDLE cycle: if acc+BAUD_RATE ≥ CLOCK_FREQ, then tick = 1 and acc <= acc+BAUD_RATE−CLOCK_FREQ; otherwise acc <= acc+BAUD_RATE.
  - Frame bit j (start bit is j=1) therefore ends ceil(j·CLOCK_FREQ/BAUD_RATE) cycles after the first start-bit cycle.
- Flow control is evaluated only at frame start. Deasserting RTS mid-frame never truncates the frame in progress.
- valid and data are ignored outside the accepting cycle; the block never stalls a frame mid-way.

## Timing
- Reset values: rxd_pin = 1, ready = 0, busy = 0, state = IDLE, acc = 0, synchroniser = 11.
- RTS latency: rtsn_pin falling to ready rising takes 2–3 cycles. rtsn_pin rising to ready falling takes 2–3 cycles.
- Accept at edge N: rxd_pin goes low and busy goes high from cycle N+1.
- With the defaults, one frame (10 bits) lasts 111 cycles. Bits last 11 or 12 cycles; the start bit lasts 12.
- Back-to-back bytes: after the stop-bit tick the block spends exactly one cycle in IDLE with rxd_pin high and ready = cts. It can accept in that cycle, giving a minimum of 1 idle cycle between frames.
- Reset mid-frame: on the next cycle rxd_pin = 1 and state = IDLE. The byte is dropped and no partial resend occurs.
- valid && ready while reset is high: the byte is ignored.

## Configuration
- RS232_XMIT_PARITY_EN defined:
  - An even-parity bit (XOR of the 8 data bits) is sent between data bit 7 and the stop bit.
  - Frames are 11 bits: 122 cycles at the defaults.
- RS232_XMIT_PARITY_EN undefined:
  - The PARITY state and its logic are absent.
  - Frames are 8N1, 10 bits.

## Test plan
- Single byte: with rtsn_pin low, send 0xA5.
  - rxd_pin reads low, then 1,0,1,0,0,1,0,1, then high.
  - Bit boundaries at cycles 12,23,34,45,56,67,78,89,100,111 after the start edge.
  - busy falls after cycle 111.
- Flow control: hold rtsn_pin high with valid = 1 for 500 cycles.
  - ready and rxd_pin stay at 0/1, with no start bit.
  - Drop rtsn_pin: the frame starts within 4 cycles.
- RTS deasserted mid-frame: raise rtsn_pin at cycle 50 of a 0x3C frame.
  - The frame completes intact.
  - The next queued byte is not accepted until rtsn_pin is low again.
- Back-to-back: stream 0x00, 0xFF, 0x55 with valid held high.
  - Exactly 1 high idle cycle between frames.
  - All 30 bits decode correctly.
- Reset mid-frame: assert reset at cycle 40 of a 0x0F frame.
  - rxd_pin = 1 and ready = 0 the next cycle.
  - After release, 0x81 sends correctly.
- With RS232_XMIT_PARITY_EN, send 0x07.
  - Parity bit = 1.
  - Frame is 122 cycles with stop bit high.
